// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_queue
//  Description : Decoupling FIFO between the fetch unit and decode. Holds
//                fetched {instr, tag} pairs until decode takes them through a
//                valid/ready handshake. Raises an early stall so fetches
//                already in flight always find room. A redirect flushes the
//                queue.
//  Options     : IFQ_BYPASS_EN - when defined, an empty queue forwards the
//                incoming instruction straight to the head outputs
//                (zero-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================

// Defaults used when global.svh has not already defined the widths.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module ifu_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int SKID  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [`INSTR_LEN-1:0]        instr_in,
    input  logic [`XLEN-1:0]             instr_tag_in,
    input  logic                         instr_valid_in,
    input  logic                         flush,
    input  logic                         deq_ready,
    output logic [`INSTR_LEN-1:0]        instr_out,
    output logic [`XLEN-1:0]             instr_tag_out,
    output logic                         instr_out_valid,
    output logic                         fetch_stall,
    output logic                         overflow,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  STALL_CNT = CNT_W'(DEPTH - SKID);

    logic [`INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [`XLEN-1:0]      tag_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Only entries actually held in the array are popped; a bypassed entry
    // never touches the pointers or the count.
    assign pop  = ~empty & deq_ready & ~flush;
    assign drop = instr_valid_in & ~flush & full;

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit      = empty & instr_valid_in & ~flush;
    assign instr_out       = bypass_hit ? instr_in     : instr_mem[rd_ptr];
    assign instr_tag_out   = bypass_hit ? instr_tag_in : tag_mem[rd_ptr];
    assign instr_out_valid = ~empty | bypass_hit;
    // A bypassed entry that decode takes immediately is never written.
    assign push = instr_valid_in & ~flush & ~full & ~(bypass_hit & deq_ready);
`else
    assign instr_out       = instr_mem[rd_ptr];
    assign instr_tag_out   = tag_mem[rd_ptr];
    assign instr_out_valid = ~empty;
    // A full queue refuses new entries even if the head leaves this cycle.
    assign push = instr_valid_in & ~flush & ~full;
`endif

    assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
    assign fetch_stall = (count >= STALL_CNT);

    // Pointer and occupancy tracking; flush outranks every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Sticky dropped-enqueue flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Entry storage is deliberately left unreset; the head is gated by valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_in;
            tag_mem[wr_ptr]   <= instr_tag_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch_queue
//  Description : Directed self-checking bench for ifu_fetch_queue
//                (DEPTH=4, SKID=2). Follows IFQ_BYPASS_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_ifu_fetch_queue;

    localparam int DEPTH = 4;
    localparam int SKID  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [`INSTR_LEN-1:0] instr_in;
    logic [`XLEN-1:0]      instr_tag_in;
    logic                  instr_valid_in;
    logic                  flush;
    logic                  deq_ready;
    logic [`INSTR_LEN-1:0] instr_out;
    logic [`XLEN-1:0]      instr_tag_out;
    logic                  instr_out_valid;
    logic                  fetch_stall;
    logic                  overflow;
    logic [2:0]            count;

    int vectors    = 0;
    int miscompares = 0;

    ifu_fetch_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_in        (instr_in),
        .instr_tag_in    (instr_tag_in),
        .instr_valid_in  (instr_valid_in),
        .flush           (flush),
        .deq_ready       (deq_ready),
        .instr_out       (instr_out),
        .instr_tag_out   (instr_tag_out),
        .instr_out_valid (instr_out_valid),
        .fetch_stall     (fetch_stall),
        .overflow        (overflow),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [`INSTR_LEN-1:0] instr_of(input logic [`XLEN-1:0] t);
        return `INSTR_LEN'(t ^ 32'hC0DE_0000);
    endfunction

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [`XLEN-1:0] t);
        instr_valid_in = v;
        instr_tag_in   = t;
        instr_in       = instr_of(t);
    endtask

    logic [`XLEN-1:0] expq[$];
    logic [`XLEN-1:0] exp_tag;
    int sent;
    int got;
    int cyc;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        deq_ready = 1'b0;
        drive(1'b0, '0);

        // ---------------- reset then idle ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", instr_out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", instr_out_valid, 0);
        chk("idle_count", count, 0);

        // ---------------- basic ordering ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i));
            tick();
            chk("fill_count", count, 64'(i + 1));
            chk("fill_stall", fetch_stall, (i + 1 >= 2) ? 1 : 0);
        end
        drive(1'b0, '0);
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("order_valid", instr_out_valid, 1);
            chk("order_tag", instr_tag_out, 32'h100 + 32'(4 * i));
            chk("order_instr", instr_out, instr_of(32'h100 + 32'(4 * i)));
            tick();
            chk("drain_count", count, 64'(2 - i));
            chk("drain_stall", fetch_stall, (2 - i >= 2) ? 1 : 0);
        end
        chk("drained_valid", instr_out_valid, 0);

        // ---------------- full queue, blocked enq + deq ----------------
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i));
            tick();
        end
        chk("full_count", count, 4);
        chk("full_stall", fetch_stall, 1);
        chk("full_ovf", overflow, 0);
        drive(1'b1, 32'hBAD);
        deq_ready = 1'b1;
        tick();
        chk("blocked_count", count, 3);
        chk("blocked_ovf", overflow, 1);
        drive(1'b0, '0);
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("blocked_tag", instr_tag_out, 32'h10 + 32'(4 * i));
            tick();
        end
        chk("blocked_empty", count, 0);
        chk("ovf_sticky", overflow, 1);

        // ---------------- flush ----------------
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i));
            tick();
        end
        flush     = 1'b1;
        deq_ready = 1'b1;
        drive(1'b1, 32'h200);
        #1;
        chk("flush_pre_valid", instr_out_valid, 1);
        tick();
        chk("flush_count", count, 0);
        chk("flush_valid", instr_out_valid, 0);
        chk("flush_stall", fetch_stall, 0);
        flush     = 1'b0;
        deq_ready = 1'b0;
        drive(1'b0, '0);
        tick();
        chk("post_flush_count", count, 0);
        chk("post_flush_valid", instr_out_valid, 0);
        chk("flush_keeps_ovf", overflow, 1);

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i));
            tick();
        end
        drive(1'b0, '0);
        chk("pre_rst_count", count, 2);
        rst_n = 1'b0;
        #2;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", instr_out_valid, 0);
        chk("async_rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- wrap-around stream ----------------
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 10 && cyc < 200) begin
            if (sent < 10 && !fetch_stall) drive(1'b1, 32'(4 * sent));
            else                           drive(1'b0, '0);
            deq_ready = (cyc % 2 == 0);
            #1;
            if (instr_valid_in) begin
                expq.push_back(instr_tag_in);
                sent++;
            end
            if (deq_ready && instr_out_valid) begin
                exp_tag = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                chk("wrap_tag", instr_tag_out, exp_tag);
                got++;
            end
            tick();
            cyc++;
            chk("wrap_count", count, 64'(expq.size()));
        end
        drive(1'b0, '0);
        deq_ready = 1'b0;
        chk("wrap_delivered", got, 10);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_empty", count, 0);

        // ---------------- bypass / minimum latency ----------------
        deq_ready = 1'b1;
        drive(1'b1, 32'h300);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_valid", instr_out_valid, 1);
        chk("byp_tag", instr_tag_out, 32'h300);
        chk("byp_instr", instr_out, instr_of(32'h300));
        tick();
        drive(1'b0, '0);
        chk("byp_count", count, 0);
        #1;
        chk("byp_after_valid", instr_out_valid, 0);
`else
        chk("lat_valid_same", instr_out_valid, 0);
        tick();
        drive(1'b0, '0);
        chk("lat_count", count, 1);
        #1;
        chk("lat_valid", instr_out_valid, 1);
        chk("lat_tag", instr_tag_out, 32'h300);
        tick();
        chk("lat_drained", count, 0);
`endif
        deq_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Decoupling FIFO directly downstream of the fetch unit.
- Accepts the fetch unit's registered instr / instr_tag / instr_valid outputs and holds them until decode accepts them with a valid/ready handshake.
- Raises an early stall back to the fetch unit so in-flight fetches always find room.
- A PC redirect (pc_load) flushes the queue.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- SKID, 2, entries kept free for fetches already in flight when stall is raised; 1 <= SKID < DEPTH.
- INSTR_LEN and XLEN come from global.svh and are not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_in  in  INSTR_LEN  instruction from the fetch unit.
- instr_tag_in  in  XLEN  PC tag of instr_in.
- instr_valid_in  in  1  instr_in / instr_tag_in are valid this cycle.
- flush  in  1  redirect (the fetch unit's pc_load); discards all contents.
- deq_ready  in  1  decode accepts the head entry this cycle.
- instr_out  out  INSTR_LEN  head instruction.
- instr_tag_out  out  XLEN  head PC tag.
- instr_out_valid  out  1  head entry valid.
- fetch_stall  out  1  drives the fetch unit's pipe_stall.
- overflow  out  1  sticky error flag: an enqueue was dropped.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry array of {instr, tag}, rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is tracked in the count register, 0..DEPTH.
- Reset (async, rst_n low): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Outputs: instr_out_valid=0, fetch_stall=0. The array is not reset; instr_out / instr_tag_out are don't-care while invalid.
- Head outputs:
  - instr_out / instr_tag_out = array[rd_ptr], combinational from registers.
  - instr_out_valid = (count != 0).
- Dequeue: deq = instr_out_valid & deq_ready & ~flush. rd_ptr advances one on the next edge.
- Enqueue: enq = instr_valid_in & ~flush & (count != DEPTH). It writes array[wr_ptr] and advances wr_ptr on the next edge.
  - Full queue: enq is blocked even if deq is asserted in the same cycle.
- Dropped input: instr_valid_in & ~flush & (count == DEPTH) sets overflow. overflow stays 1 until reset; flush does not clear it.
- Count update: count_next = count + enq - deq. Simultaneous enq and deq with 0 < count < DEPTH leaves count unchanged.
- Latency: an entry enqueued at edge N appears at the head after edge N, i.e. one cycle, when the queue was empty. The queue has no bypass (see Optional Feature).
- fetch_stall = (count >= DEPTH - SKID), combinational from count. SKID covers the fetch unit's one-cycle output register plus the cycle of stall propagation.
- Flush has priority over everything:
  - On the edge where flush=1: rd_ptr=0, wr_ptr=0, count=0.
  - Any instr_valid_in in that cycle is discarded; deq_ready is ignored.
  - instr_out_valid is 0 in the cycle after flush. fetch_stall drops the cycle after flush.
  - While flush is high, instr_out_valid reflects the pre-flush count; decode must itself ignore it when pc_load is high.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Reset mid-operation: all state is cleared immediately; queued contents are lost.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count==0 and instr_valid_in & ~flush, the head outputs are driven combinationally from instr_in / instr_tag_in, with instr_out_valid=1.
  - If deq_ready is also 1, the entry is consumed without being written and count stays 0.
  - If deq_ready is 0, the entry is written normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; one-cycle minimum latency as above.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with no input -> instr_out_valid=0, count=0, fetch_stall=0, overflow=0.
- Basic ordering: enqueue tags 0x100, 0x104, 0x108 on consecutive cycles with deq_ready=0, then deq_ready=1 -> head order 0x100, 0x104, 0x108; count 3->0; fetch_stall=1 while count>=2 (DEPTH=4, SKID=2).
- Full, blocked enq+deq: fill 4 entries, hold instr_valid_in=1 with deq_ready=1 one cycle -> that input dropped, overflow=1; count 3 next cycle; overflow remains 1.
- Flush: 3 entries queued, flush=1 with instr_valid_in=1 (tag 0x200) -> next cycle count=0, instr_out_valid=0, fetch_stall=0; 0x200 never appears at the head.
- Wrap-around: stream 10 instructions (tags 0x0..0x24, step 4) with deq_ready toggling 1,0,1,0 -> all 10 delivered in order, no loss, overflow=0, pointers wrap twice.
- Bypass (IFQ_BYPASS_EN defined): empty queue, instr_valid_in=1 tag 0x300, deq_ready=1 -> instr_out_valid=1 with tag 0x300 the same cycle; count stays 0. Without the macro, the tag appears one cycle later.
